exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the single-cycle CPU.
- Sits between the instruction decoder and the program-counter register and arbitrates the final PC source select.
- Merges the decoder's requested PC source with illegal-opcode and external interrupt events, and latches/prioritises pending IRQs.
- Produces the exception return address (EPC) for $k0 and tracks user/kernel mode.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines; index 0 is highest priority.
- ILLOP_SEL, 3'b100, PC source code that selects the illegal-op vector 0x8000_0004.
- XADR_SEL, 3'b101, PC source code that selects the interrupt vector 0x8000_0008.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- pc, input, 32, current PC; bit 31 = supervisor bit.
- pc_src_in, input, 3, PC source requested by the decoder (000 seq, 001 branch, 010 j/jal, 011 jr/jalr).
- jr_tgt31, input, 1, bit 31 of the jr/jalr target (DatabusA[31]).
- illop, input, 1, decoder flags an undefined instruction this cycle.
- irq_in, input, NUM_IRQ, external interrupt lines, rising-edge sensitive.
- mask_we, input, 1, write strobe for the IRQ mask.
- mask_wdata, input, NUM_IRQ, mask data; 1 = enabled.
- pc_src_out, output, 3, final PC source driven to the PC register.
- kill, output, 1, squash register-file and memory writes of the current instruction.
- epc_we, output, 1, write EPC into $k0 ($26) this cycle.
- epc, output, 32, return address to write.
- irq_ack, output, NUM_IRQ, one-hot pulse marking the IRQ being taken.
- in_kernel, output, 1, 1 while the state is KERN.

Behaviour:
- Reset values (asynchronous, reset=0): state=USER, pending=0, mask=all ones, irq_in edge-detect register=0. All outputs are combinational from state and inputs; with illop=0 and irq_in=0 they read pc_src_out=pc_src_in, kill=0, epc_we=0, epc=0, irq_ack=0, in_kernel=0.
- Edge detect: pending[i] sets on a 0->1 transition of irq_in[i] between consecutive clk edges. pending[i] clears on the clock edge where irq_ack[i]=1. If a new edge on bit i arrives in the same cycle that bit i is acked, the edge is merged and pending[i] ends at 0.
- Eligibility: eligible = pending & mask. The taken IRQ is the lowest eligible index.
- mask_we updates mask at the clock edge. The new mask takes effect from the next cycle.
- State USER, with pc[31]=0 (all paths below are combinational in the same cycle):
  - illop=1: pc_src_out=ILLOP_SEL, kill=1, epc_we=1, epc=pc+4, next state=KERN. illop has priority over IRQs; pending IRQs stay pending.
  - Otherwise, if eligible!=0: pc_src_out=XADR_SEL, kill=1, epc_we=1, epc=pc (the squashed instruction re-executes), irq_ack pulses the winner, next state=KERN.
  - Otherwise: pc_src_out=pc_src_in.
- State KERN:
  - IRQs are never taken; edges still accumulate in pending.
  - illop in KERN: pc_src_out=ILLOP_SEL, kill=1, epc_we=0 (EPC is preserved), stay in KERN.
  - pc_src_in=011 with jr_tgt31=0: pass through, next state=RET.
- State RET lasts one cycle:
  - The first user instruction always executes, so IRQs are blocked this cycle.
  - illop is still handled as in USER.
  - Next state=USER (or KERN if illop).
- If pc[31]=1 while the state is USER (a kernel jump not caused by this block), the block treats the state as KERN from the next edge.
- epc arithmetic is 32-bit modulo; bit 31 is taken from pc unchanged.
- Reset mid-handler returns to USER and clears pending. The PC reset vector is the PC register's responsibility.

Optional Feature:
- Macro EXC_CAUSE_EN.
- When defined: adds output cause[4:0] and input cause_clr.
  - On entry the cause register latches {1'b0, 4'd0} for illop or {1'b1, index} for an IRQ.
  - cause holds until cause_clr or the next entry.
  - Reset value is 0.
- When undefined: no cause port and no cause register.

Test Plan:
- Reset release, pc=0x0040_0010, pc_src_in=001, no events -> pc_src_out=001, kill=0, in_kernel=0, mask=4'hF.
- irq_in[2] rises with pc=0x0040_0020 -> next cycle pc_src_out=101, kill=1, epc_we=1, epc=0x0040_0020, irq_ack=4'b0100, then in_kernel=1.
- illop together with pending IRQ1 at pc=0x0040_0100 -> pc_src_out=100, epc=0x0040_0104. IRQ1 stays pending and is taken on the first cycle after the RET cycle that follows jr to 0x0040_0104.
- irq_in[3] and irq_in[1] both rise in KERN, mask=4'b0111 -> after return only IRQ1 is acked; IRQ3 is acked only after a mask_we with mask_wdata=4'hF.
- Reset asserted in KERN with pending=4'b0011 -> immediately state=USER, pending=0, in_kernel=0, epc_we=0.
- With EXC_CAUSE_EN: IRQ2 taken -> cause=5'b10010; cause_clr pulse -> cause=0.

Source files
------------

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt sequencer for the single-cycle CPU.
//
// Sits between the instruction decoder and the PC register. It merges the
// decoder's PC source request with illegal-opcode and external interrupt
// events, and produces the final PC source select. It also generates the
// exception return address (EPC) written to $k0 and tracks user/kernel mode.
//
// Optional feature: define EXC_CAUSE_EN to add a cause register
// (cause_o[4:0], cleared by cause_clr_i).
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   pc_i          current PC, bit 31 is the supervisor bit
//   pc_src_in_i   decoder PC source (000 seq, 001 br, 010 j/jal, 011 jr/jalr)
//   jr_tgt31_i    bit 31 of the jr/jalr target
//   illop_i       undefined instruction in this cycle
//   irq_in_i      external interrupt lines, rising-edge sensitive
//   mask_we_i     IRQ mask write strobe
//   mask_wdata_i  IRQ mask write data, 1 = enabled
//   cause_clr_i   (EXC_CAUSE_EN) clear the cause register
//   cause_o       (EXC_CAUSE_EN) {is_irq, index} of the last entry
//   pc_src_out_o  final PC source to the PC register
//   kill_o        squash register-file and memory writes this cycle
//   epc_we_o      write epc_o into $k0 this cycle
//   epc_o         return address to write
//   irq_ack_o     one-hot pulse marking the IRQ being taken
//   in_kernel_o   high while in kernel state
// ---------------------------------------------------------------------------
module exc_ctrl #(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [2:0]  ILLOP_SEL = 3'b100,
    parameter logic [2:0]  XADR_SEL  = 3'b101
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_i,
    input  logic [2:0]         pc_src_in_i,
    input  logic               jr_tgt31_i,
    input  logic               illop_i,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
`ifdef EXC_CAUSE_EN
    input  logic               cause_clr_i,
    output logic [4:0]         cause_o,
`endif
    output logic [2:0]         pc_src_out_o,
    output logic               kill_o,
    output logic               epc_we_o,
    output logic [31:0]        epc_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               in_kernel_o
);

    localparam int unsigned IdxW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [2:0]  JrSel = 3'b011;

    typedef enum logic [1:0] {
        StUser = 2'b00,
        StKern = 2'b01,
        StRet  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] irq_q;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] win_oh;
    logic [IdxW-1:0]    win_idx;
    logic               win_found;
    logic               take_ill;
    logic               take_irq;
    logic [31:0]        pc_plus4;

    assign eligible = pending_q & mask_q;

    // Lowest eligible index wins.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !win_found) begin
                win_found  = 1'b1;
                win_oh[i]  = 1'b1;
                win_idx    = IdxW'(i);
            end
        end
    end

    // Supervisor bit is carried through; only the low 31 bits wrap.
    assign pc_plus4 = {pc_i[31], pc_i[30:0] + 31'd4};

    always_comb begin
        pc_src_out_o = pc_src_in_i;
        kill_o       = 1'b0;
        epc_we_o     = 1'b0;
        epc_o        = '0;
        irq_ack_o    = '0;
        take_ill     = 1'b0;
        take_irq     = 1'b0;
        state_d      = state_q;

        unique case (state_q)
            StKern: begin
                // Nested illop: vector again but keep the saved EPC.
                if (illop_i) begin
                    pc_src_out_o = ILLOP_SEL;
                    kill_o       = 1'b1;
                end else if (pc_src_in_i == JrSel && !jr_tgt31_i) begin
                    state_d = StRet;
                end
            end
            StUser, StRet: begin
                if (illop_i) begin
                    pc_src_out_o = ILLOP_SEL;
                    kill_o       = 1'b1;
                    epc_we_o     = 1'b1;
                    epc_o        = pc_plus4;
                    take_ill     = 1'b1;
                    state_d      = StKern;
                end else if (state_q == StUser && !pc_i[31] && win_found) begin
                    // The squashed instruction re-executes on return.
                    pc_src_out_o = XADR_SEL;
                    kill_o       = 1'b1;
                    epc_we_o     = 1'b1;
                    epc_o        = pc_i;
                    irq_ack_o    = win_oh;
                    take_irq     = 1'b1;
                    state_d      = StKern;
                end else if (state_q == StRet) begin
                    state_d = StUser;
                end else if (pc_i[31]) begin
                    // Kernel entry not caused by this block.
                    state_d = StKern;
                end
            end
            default: state_d = StUser;
        endcase
    end

    // An edge arriving on the cycle its bit is acked is merged into that ack.
    assign pending_d = (pending_q | (irq_in_i & ~irq_q)) & ~irq_ack_o;

    assign in_kernel_o = (state_q == StKern);

`ifdef EXC_CAUSE_EN
    logic [4:0] cause_q;
    assign cause_o = cause_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StUser;
            pending_q <= '0;
            mask_q    <= '1;
            irq_q     <= '0;
`ifdef EXC_CAUSE_EN
            cause_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_q     <= irq_in_i;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
`ifdef EXC_CAUSE_EN
            // A new entry takes precedence over a clear in the same cycle.
            if (take_ill) begin
                cause_q <= 5'd0;
            end else if (take_irq) begin
                cause_q <= {1'b1, 4'(win_idx)};
            end else if (cause_clr_i) begin
                cause_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl -- self-checking bench for exc_ctrl.
// A behavioural model (mode, pending, mask, previous irq sample) predicts the
// outputs every cycle; directed sequences also check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

    localparam int M_USER = 0;
    localparam int M_KERN = 1;
    localparam int M_RET  = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [2:0]  pc_src_in;
    logic        jr_tgt31;
    logic        illop;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        cause_clr;
    logic [2:0]  pc_src_out;
    logic        kill;
    logic        epc_we;
    logic [31:0] epc;
    logic [3:0]  irq_ack;
    logic        in_kernel;
    logic [4:0]  cause;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    exc_ctrl #(
        .NUM_IRQ   (4),
        .ILLOP_SEL (3'b100),
        .XADR_SEL  (3'b101)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (pc),
        .pc_src_in_i  (pc_src_in),
        .jr_tgt31_i   (jr_tgt31),
        .illop_i      (illop),
        .irq_in_i     (irq_in),
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
`ifdef EXC_CAUSE_EN
        .cause_clr_i  (cause_clr),
        .cause_o      (cause),
`endif
        .pc_src_out_o (pc_src_out),
        .kill_o       (kill),
        .epc_we_o     (epc_we),
        .epc_o        (epc),
        .irq_ack_o    (irq_ack),
        .in_kernel_o  (in_kernel)
    );

`ifndef EXC_CAUSE_EN
    assign cause = 5'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [2:0]  src;
        logic        kill;
        logic        we;
        logic [31:0] epc;
        logic [3:0]  ack;
        logic        kern;
        logic [1:0]  nxt;
        logic        ent;
        logic [4:0]  cval;
    } exp_t;

    int         m_mode;
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_prev;
    logic [4:0] m_cause;
    exp_t       me;

    function automatic exp_t model_eval(input int mode, input logic [3:0] pend,
                                        input logic [3:0] msk, input logic [31:0] p,
                                        input logic [2:0] src, input logic jt,
                                        input logic ill);
        exp_t       e;
        logic [3:0] elig;
        int         win;
        e      = '0;
        e.src  = src;
        e.kern = (mode == M_KERN);
        e.nxt  = 2'(mode);
        elig   = pend & msk;
        win    = -1;
        for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
        if (mode == M_KERN) begin
            if (ill) begin
                e.src  = 3'd4;
                e.kill = 1'b1;
            end else if (src == 3'd3 && !jt) begin
                e.nxt = 2'(M_RET);
            end
        end else if (ill) begin
            e.src  = 3'd4;
            e.kill = 1'b1;
            e.we   = 1'b1;
            e.epc  = ((p + 32'd4) & 32'h7FFF_FFFF) | (p & 32'h8000_0000);
            e.nxt  = 2'(M_KERN);
            e.ent  = 1'b1;
            e.cval = 5'd0;
        end else if (mode == M_USER && !p[31] && win >= 0) begin
            e.src  = 3'd5;
            e.kill = 1'b1;
            e.we   = 1'b1;
            e.epc  = p;
            e.ack  = 4'(1 << win);
            e.nxt  = 2'(M_KERN);
            e.ent  = 1'b1;
            e.cval = 5'(16 + win);
        end else if (mode == M_RET) begin
            e.nxt = 2'(M_USER);
        end else if (p[31]) begin
            e.nxt = 2'(M_KERN);
        end
        return e;
    endfunction

    function automatic logic [3:0] pend_next(input logic [3:0] p, input logic [3:0] prev,
                                             input logic [3:0] cur, input logic [3:0] ack);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) r[i] = 1'b0;
            else if (cur[i] && !prev[i]) r[i] = 1'b1;
            else r[i] = p[i];
        end
        return r;
    endfunction

    always_comb me = model_eval(m_mode, m_pend, m_mask, pc, pc_src_in, jr_tgt31, illop);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode  <= M_USER;
            m_pend  <= 4'h0;
            m_mask  <= 4'hF;
            m_prev  <= 4'h0;
            m_cause <= 5'd0;
        end else begin
            m_mode <= int'(me.nxt);
            m_pend <= pend_next(m_pend, m_prev, irq_in, me.ack);
            m_prev <= irq_in;
            if (mask_we) m_mask <= mask_wdata;
            if (me.ent) m_cause <= me.cval;
            else if (cause_clr) m_cause <= 5'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_src", 32'(pc_src_out), 32'(me.src));
            chk("m_kill", 32'(kill), 32'(me.kill));
            chk("m_epc_we", 32'(epc_we), 32'(me.we));
            chk("m_epc", epc, me.epc);
            chk("m_ack", 32'(irq_ack), 32'(me.ack));
            chk("m_kern", 32'(in_kernel), 32'(me.kern));
`ifdef EXC_CAUSE_EN
            chk("m_cause", 32'(cause), 32'(m_cause));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [2:0] s, input logic jt,
                         input logic il);
        pc        = p;
        pc_src_in = s;
        jr_tgt31  = jt;
        illop     = il;
    endtask

    initial begin
        reset      = 1'b0;
        cause_clr  = 1'b0;
        irq_in     = 4'h0;
        mask_we    = 1'b0;
        mask_wdata = 4'h0;
        drive(32'h0040_0010, 3'b001, 1'b0, 1'b0);
        #2;
        chk("rst_src", 32'(pc_src_out), 32'd1);
        chk("rst_kill", 32'(kill), 32'd0);
        chk("rst_epc_we", 32'(epc_we), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_ack", 32'(irq_ack), 32'd0);
        chk("rst_kern", 32'(in_kernel), 32'd0);
        cyc();
        reset  = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rel_src", 32'(pc_src_out), 32'd1);
        chk("rel_kill", 32'(kill), 32'd0);

        // IRQ2 edge, taken the cycle after it is latched.
        cyc(); drive(32'h0040_0020, 3'd0, 1'b0, 1'b0); irq_in = 4'b0100;
        cyc(); #1;
        chk("irq2_src", 32'(pc_src_out), 32'd5);
        chk("irq2_kill", 32'(kill), 32'd1);
        chk("irq2_we", 32'(epc_we), 32'd1);
        chk("irq2_epc", epc, 32'h0040_0020);
        chk("irq2_ack", 32'(irq_ack), 32'b0100);
        cyc(); drive(32'h8000_0008, 3'd0, 1'b0, 1'b0); cause_clr = 1'b1; #1;
        chk("irq2_kern", 32'(in_kernel), 32'd1);
        chk("irq2_noack", 32'(irq_ack), 32'd0);
`ifdef EXC_CAUSE_EN
        chk("cause_irq2", 32'(cause), 32'b10010);
`endif
        cyc(); drive(32'h8000_000C, 3'd3, 1'b0, 1'b0); irq_in = 4'h0; cause_clr = 1'b0;
`ifdef EXC_CAUSE_EN
        #1; chk("cause_clr", 32'(cause), 32'd0);
`endif
        cyc(); drive(32'h0040_0020, 3'd0, 1'b0, 1'b0); #1;
        chk("ret_kern", 32'(in_kernel), 32'd0);

        // illop beats pending IRQ1; IRQ1 taken after the RET cycle.
        cyc(); drive(32'h0040_0024, 3'd0, 1'b0, 1'b0); irq_in = 4'b0010;
        cyc(); drive(32'h0040_0100, 3'd0, 1'b0, 1'b1); #1;
        chk("ill_src", 32'(pc_src_out), 32'd4);
        chk("ill_epc", epc, 32'h0040_0104);
        chk("ill_ack", 32'(irq_ack), 32'd0);
        cyc(); drive(32'h8000_0004, 3'd3, 1'b0, 1'b0); #1;
        chk("ill_kern", 32'(in_kernel), 32'd1);
        cyc(); drive(32'h0040_0104, 3'd0, 1'b0, 1'b0); #1;
        chk("ret_block_ack", 32'(irq_ack), 32'd0);
        chk("ret_block_kill", 32'(kill), 32'd0);
        cyc(); drive(32'h0040_0108, 3'd0, 1'b0, 1'b0); #1;
        chk("irq1_src", 32'(pc_src_out), 32'd5);
        chk("irq1_ack", 32'(irq_ack), 32'b0010);
        chk("irq1_epc", epc, 32'h0040_0108);

        // Mask 0111: IRQ3 held off until the mask is reopened.
        cyc(); drive(32'h8000_0008, 3'd0, 1'b0, 1'b0); irq_in = 4'h0;
        mask_we = 1'b1; mask_wdata = 4'b0111;
        cyc(); mask_we = 1'b0; irq_in = 4'b1010; drive(32'h8000_000C, 3'd0, 1'b0, 1'b0);
        cyc(); drive(32'h8000_0010, 3'd3, 1'b0, 1'b0); #1;
        chk("kern_noack", 32'(irq_ack), 32'd0);
        cyc(); drive(32'h0040_0108, 3'd0, 1'b0, 1'b0);
        cyc(); drive(32'h0040_010C, 3'd0, 1'b0, 1'b0); #1;
        chk("mask_irq1", 32'(irq_ack), 32'b0010);
        cyc(); drive(32'h8000_0008, 3'd3, 1'b0, 1'b0);
        cyc(); drive(32'h0040_010C, 3'd0, 1'b0, 1'b0);
        cyc(); drive(32'h0040_0110, 3'd0, 1'b0, 1'b0); mask_we = 1'b1; mask_wdata = 4'hF; #1;
        chk("mask_irq3_held", 32'(irq_ack), 32'd0);
        chk("mask_irq3_kill", 32'(kill), 32'd0);
        cyc(); mask_we = 1'b0; drive(32'h0040_0114, 3'd0, 1'b0, 1'b0); #1;
        chk("mask_irq3", 32'(irq_ack), 32'b1000);
        chk("mask_irq3_epc", epc, 32'h0040_0114);

        // Reset in KERN with pending 0011.
        cyc(); drive(32'h8000_0008, 3'd0, 1'b0, 1'b0); irq_in = 4'h0;
        cyc(); irq_in = 4'b0011;
        cyc(); #1;
        chk("pre_rst_kern", 32'(in_kernel), 32'd1);
        reset = 1'b0; irq_in = 4'h0; #1;
        chk("mid_rst_kern", 32'(in_kernel), 32'd0);
        chk("mid_rst_we", 32'(epc_we), 32'd0);
        chk("mid_rst_src", 32'(pc_src_out), 32'd0);
        cyc(); reset = 1'b1; drive(32'h0040_0200, 3'd0, 1'b0, 1'b0); #1;
        chk("post_rst_ack", 32'(irq_ack), 32'd0);
        cyc(); #1;
        chk("post_rst_ack2", 32'(irq_ack), 32'd0);
        chk("post_rst_kill", 32'(kill), 32'd0);

        // EPC wrap keeps bit 31 from pc; nested illop keeps EPC.
        cyc(); drive(32'h7FFF_FFFC, 3'd0, 1'b0, 1'b1); #1;
        chk("wrap_epc", epc, 32'h0000_0000);
        chk("wrap_src", 32'(pc_src_out), 32'd4);
        cyc(); drive(32'h8000_0004, 3'd2, 1'b0, 1'b1); #1;
        chk("nest_src", 32'(pc_src_out), 32'd4);
        chk("nest_kill", 32'(kill), 32'd1);
        chk("nest_we", 32'(epc_we), 32'd0);
        cyc(); drive(32'h8000_0008, 3'd3, 1'b1, 1'b0);
        cyc(); drive(32'h8000_000C, 3'd0, 1'b0, 1'b0); #1;
        chk("jr_kern_stay", 32'(in_kernel), 32'd1);

        // Randomized phase, model-checked every cycle.
        for (int n = 0; n < 4000; n++) begin
            cyc();
            if (m_mode == M_KERN) pc = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            else if ($urandom_range(0, 31) == 0) pc = 32'h7FFF_FFFC;
            else pc = $urandom & 32'h7FFF_FFFC;
            pc_src_in = 3'($urandom_range(0, 3));
            jr_tgt31  = 1'($urandom_range(0, 1));
            illop     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) irq_in[$urandom_range(0, 3)] ^= 1'b1;
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            cause_clr  = ($urandom_range(0, 7) == 0);
        end

        cyc();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
